// File: rtl/heavy_part_compare_update2_pkg.sv
// rtl/heavy_part_compare_update2_pkg.sv - shared field layout and defaults for the lane-2 heavy-part update stage
package heavy_part_compare_update2_pkg;

  localparam int ADDR_W        = 12;
  localparam int ITEM_W        = 128;
  localparam int BUCKET_W      = 96;
  localparam int LIGHT_W       = 64;
  localparam int LIGHT_DEPTH   = 512;

  localparam int ITEM_KEY_HI   = 63;
  localparam int ITEM_KEY_LO   = 32;
  localparam int ITEM_VAL_HI   = 31;
  localparam int ITEM_VAL_LO   = 0;

  localparam int KEY_HI        = 95;
  localparam int KEY_LO        = 64;
  localparam int VPOS_HI       = 63;
  localparam int VPOS_LO       = 32;
  localparam int FLAG_BIT      = 31;
  localparam int VNEG_HI       = 30;
  localparam int VNEG_LO       = 0;

  localparam int RAM_LAT_DEF   = 2;
  localparam int LAMBDA_DEF    = 8;
  localparam int ALF_LEVEL_DEF = 384;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] vote_pos;
    logic        flag;
    logic [30:0] vote_neg;
  } bucket_t;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] count;
  } light_t;

endpackage

// File: rtl/heavy_part_compare_update2_if.sv
// rtl/heavy_part_compare_update2_if.sv - item, bucket RAM and light-part signals of the lane-2 update stage
interface heavy_part_compare_update2_if;
  import heavy_part_compare_update2_pkg::*;

  logic                item_in_wr2;
  logic [ITEM_W-1:0]   item_in2;
  logic                item_alf2;
  logic [ADDR_W-1:0]   bucket_addr2;
  logic [BUCKET_W-1:0] ram_q2;
  logic                ram_wren2;
  logic [ADDR_W-1:0]   ram_wraddr2;
  logic [BUCKET_W-1:0] ram_wrdata2;
  logic                light_out_wr2;
  logic [LIGHT_W-1:0]  light_out2;
  logic                light_out_alf2;

  modport slave (
    input  item_in_wr2, item_in2, bucket_addr2, ram_q2, light_out_alf2,
    output item_alf2, ram_wren2, ram_wraddr2, ram_wrdata2, light_out_wr2, light_out2
  );

  modport master (
    output item_in_wr2, item_in2, bucket_addr2, ram_q2, light_out_alf2,
    input  item_alf2, ram_wren2, ram_wraddr2, ram_wrdata2, light_out_wr2, light_out2
  );

endinterface

// File: rtl/heavy_part_compare_update2_fifo_64_512.sv
// rtl/heavy_part_compare_update2_fifo_64_512.sv - light-part record FIFO with registered read data and fill level
module fifo_64_512 #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_usedw,
  output logic             o_overflow_err
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_overflow_err;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty        = (r_count == '0);
  assign o_full         = (r_count == (AW+1)'(DEPTH));
  assign o_usedw        = r_count;
  assign o_pop_data     = r_rd_data;
  assign o_overflow_err = r_overflow_err;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rd_data      <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && o_full) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/heavy_part_compare_update2.sv
// rtl/heavy_part_compare_update2.sv - Elastic Sketch heavy-part vote/update for lane 2 with write-back forwarding
module heavy_part_compare_update2
  import heavy_part_compare_update2_pkg::*;
#(
  parameter int RAM_LAT   = RAM_LAT_DEF,
  parameter int LAMBDA    = LAMBDA_DEF,
  parameter int ALF_LEVEL = ALF_LEVEL_DEF
) (
  input logic clk,
  input logic reset,
  heavy_part_compare_update2_if.slave bus
);

  localparam int HIST    = RAM_LAT + 1;
  localparam int USEDW_W = $clog2(LIGHT_DEPTH) + 1;

  logic              r_dly_vld  [RAM_LAT];
  logic [ADDR_W-1:0] r_dly_addr [RAM_LAT];
  logic [31:0]       r_dly_key  [RAM_LAT];
  logic [31:0]       r_dly_val  [RAM_LAT];

  logic              r_hist_vld  [HIST];
  logic [ADDR_W-1:0] r_hist_addr [HIST];
  bucket_t           r_hist_data [HIST];

  logic              r_light_wr;

  logic              w_e_vld;
  logic [ADDR_W-1:0] w_e_addr;
  logic [31:0]       w_e_key;
  logic [31:0]       w_e_val;
  bucket_t           w_bucket;
  bucket_t           w_new;
  logic [32:0]       w_vpos_sum;
  logic [31:0]       w_vpos_new;
  logic [32:0]       w_vneg_sum;
  logic [30:0]       w_vneg_new;
  logic [34:0]       w_thresh;
  logic              w_evict;
  logic              w_push;
  light_t            w_push_data;
  logic              w_pop;
  logic [LIGHT_W-1:0] w_pop_data;
  logic              w_empty;
  logic              w_full;
  logic [USEDW_W-1:0] w_usedw;
  logic              w_overflow_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        r_dly_vld[i]  <= 1'b0;
        r_dly_addr[i] <= '0;
        r_dly_key[i]  <= '0;
        r_dly_val[i]  <= '0;
      end
    end else begin
      r_dly_vld[0]  <= bus.item_in_wr2;
      r_dly_addr[0] <= bus.bucket_addr2;
      r_dly_key[0]  <= bus.item_in2[ITEM_KEY_HI:ITEM_KEY_LO];
      r_dly_val[0]  <= bus.item_in2[ITEM_VAL_HI:ITEM_VAL_LO];
      for (int i = 1; i < RAM_LAT; i++) begin
        r_dly_vld[i]  <= r_dly_vld[i-1];
        r_dly_addr[i] <= r_dly_addr[i-1];
        r_dly_key[i]  <= r_dly_key[i-1];
        r_dly_val[i]  <= r_dly_val[i-1];
      end
    end
  end

  assign w_e_vld  = r_dly_vld[RAM_LAT-1];
  assign w_e_addr = r_dly_addr[RAM_LAT-1];
  assign w_e_key  = r_dly_key[RAM_LAT-1];
  assign w_e_val  = r_dly_val[RAM_LAT-1];

  // Entry 0 is the write currently on the RAM port; scanning oldest-first lets the youngest match win.
  always_comb begin
    w_bucket = bucket_t'(bus.ram_q2);
    for (int i = HIST - 1; i >= 0; i--) begin
      if (r_hist_vld[i] && (r_hist_addr[i] == w_e_addr)) begin
        w_bucket = r_hist_data[i];
      end
    end
  end

  assign w_vpos_sum = {1'b0, w_bucket.vote_pos} + {1'b0, w_e_val};
  assign w_vpos_new = w_vpos_sum[32] ? 32'hFFFF_FFFF : w_vpos_sum[31:0];
  assign w_vneg_sum = {2'b00, w_bucket.vote_neg} + {1'b0, w_e_val};
  assign w_vneg_new = (w_vneg_sum[32:31] != 2'b00) ? 31'h7FFF_FFFF : w_vneg_sum[30:0];
  assign w_thresh   = 35'(LAMBDA) * {3'b000, w_bucket.vote_pos};
  assign w_evict    = ({4'b0000, w_vneg_new} >= w_thresh);

  always_comb begin
    w_new       = w_bucket;
    w_push      = 1'b0;
    w_push_data = '0;
    if (w_bucket.vote_pos == 32'd0) begin
      w_new = '{key: w_e_key, vote_pos: w_e_val, flag: 1'b0, vote_neg: 31'd0};
    end else if (w_bucket.key == w_e_key) begin
      w_new.vote_pos = w_vpos_new;
    end else if (w_evict) begin
      w_new       = '{key: w_e_key, vote_pos: w_e_val, flag: 1'b1, vote_neg: 31'd0};
      w_push      = w_e_vld;
      w_push_data = '{key: w_bucket.key, count: w_bucket.vote_pos};
    end else begin
      w_new.vote_neg = w_vneg_new;
      w_push         = w_e_vld;
      w_push_data    = '{key: w_e_key, count: w_e_val};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HIST; i++) begin
        r_hist_vld[i]  <= 1'b0;
        r_hist_addr[i] <= '0;
        r_hist_data[i] <= '0;
      end
      r_light_wr <= 1'b0;
    end else begin
      r_hist_vld[0]  <= w_e_vld;
      r_hist_addr[0] <= w_e_addr;
      r_hist_data[0] <= w_new;
      for (int i = 1; i < HIST; i++) begin
        r_hist_vld[i]  <= r_hist_vld[i-1];
        r_hist_addr[i] <= r_hist_addr[i-1];
        r_hist_data[i] <= r_hist_data[i-1];
      end
      r_light_wr <= w_pop;
    end
  end

  assign bus.ram_wren2   = r_hist_vld[0];
  assign bus.ram_wraddr2 = r_hist_addr[0];
  assign bus.ram_wrdata2 = r_hist_data[0];

  assign w_pop = !w_empty && !bus.light_out_alf2;

  fifo_64_512 #(
    .WIDTH (LIGHT_W),
    .DEPTH (LIGHT_DEPTH)
  ) u_light_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_data    (w_push_data),
    .i_pop          (w_pop),
    .o_pop_data     (w_pop_data),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .o_usedw        (w_usedw),
    .o_overflow_err (w_overflow_err)
  );

  assign bus.light_out_wr2 = r_light_wr;
  assign bus.light_out2    = w_pop_data;
  assign bus.item_alf2     = (w_usedw >= USEDW_W'(ALF_LEVEL));

  a_no_light_overflow: assert property (@(posedge clk) disable iff (!reset) !w_overflow_err);

endmodule

// File: tb/tb_heavy_part_compare_update2.sv
// tb/tb_heavy_part_compare_update2.sv - scoreboard bench with a program-order bucket model and a latency-2 RAM
module tb_heavy_part_compare_update2;
  import heavy_part_compare_update2_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  heavy_part_compare_update2_if bus();

  heavy_part_compare_update2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0]  mem     [4096];
  logic [95:0]  ref_mem [4096];
  logic [95:0]  rq1;
  logic [107:0] exp_wr_q [$];
  logic [63:0]  exp_lt_q [$];
  bit           alf_phase = 1'b0;
  int           alf_pushes = 0;

  always @(posedge clk) begin
    rq1        <= mem[bus.bucket_addr2];
    bus.ram_q2 <= rq1;
    if (bus.ram_wren2) mem[bus.ram_wraddr2] <= bus.ram_wrdata2;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [11:0] a, input logic [31:0] k, input logic [31:0] v);
    logic [31:0] bk, vp;
    logic        bf;
    logic [30:0] vn;
    longint      s;
    {bk, vp, bf, vn} = ref_mem[a];
    if (vp == 0) begin
      ref_mem[a] = {k, v, 1'b0, 31'd0};
    end else if (bk == k) begin
      s = longint'(vp) + longint'(v);
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
      ref_mem[a] = {bk, s[31:0], bf, vn};
    end else begin
      s = longint'(vn) + longint'(v);
      if (s > 64'h7FFF_FFFF) s = 64'h7FFF_FFFF;
      if (s >= longint'(LAMBDA_DEF) * longint'(vp)) begin
        ref_mem[a] = {k, v, 1'b1, 31'd0};
        exp_lt_q.push_back({bk, vp});
      end else begin
        ref_mem[a] = {bk, vp, bf, s[30:0]};
        exp_lt_q.push_back({k, v});
      end
    end
    exp_wr_q.push_back({a, ref_mem[a]});
  endfunction

  task automatic preload(input logic [11:0] a, input logic [95:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic send(input logic [11:0] a, input logic [31:0] k, input logic [31:0] v);
    model(a, k, v);
    bus.item_in_wr2  = 1'b1;
    bus.item_in2     = {$urandom, $urandom, k, v};
    bus.bucket_addr2 = a;
    @(posedge clk);
    #1;
    bus.item_in_wr2  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_wr_q.size() == 0 && exp_lt_q.size() == 0) break;
      @(posedge clk);
    end
    check({name, "_wr_left"}, exp_wr_q.size(), 0);
    check({name, "_lt_left"}, exp_lt_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.ram_wren2) begin
        if (exp_wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", bus.ram_wraddr2, bus.ram_wrdata2);
        end else begin
          check("ram_write", {bus.ram_wraddr2, bus.ram_wrdata2}, exp_wr_q.pop_front());
        end
      end
      if (bus.light_out_wr2) begin
        if (exp_lt_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_light: got %h expected none", bus.light_out2);
        end else begin
          check("light_out", bus.light_out2, exp_lt_q.pop_front());
        end
      end
      if (alf_phase) begin
        if (bus.ram_wren2) alf_pushes++;
        check("item_alf2_level", bus.item_alf2, (alf_pushes >= ALF_LEVEL_DEF));
      end
    end
  end

  initial begin
    logic [11:0] a;
    logic [31:0] k, v;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    bus.item_in_wr2    = 1'b0;
    bus.item_in2       = '0;
    bus.bucket_addr2   = '0;
    bus.light_out_alf2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wren",    bus.ram_wren2, 0);
    check("rst_wraddr",  bus.ram_wraddr2, 0);
    check("rst_wrdata",  bus.ram_wrdata2, 0);
    check("rst_light_wr", bus.light_out_wr2, 0);
    check("rst_light",   bus.light_out2, 0);
    check("rst_alf",     bus.item_alf2, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed cases: empty, hit, miss, evict, then back-to-back on a stale address
    preload(12'd10, {32'h0000_00AA, 32'd10, 1'b0, 31'd0});
    preload(12'd11, {32'h0000_00AA, 32'd10, 1'b0, 31'd0});
    preload(12'd12, {32'h0000_00AA, 32'd1,  1'b0, 31'd5});
    send(12'd5,  32'h0A00_0001, 32'd3);
    send(12'd10, 32'h0000_00AA, 32'd4);
    send(12'd11, 32'h0000_00BB, 32'd5);
    send(12'd12, 32'h0000_00BB, 32'd3);
    send(12'd7,  32'h0000_00CC, 32'd2);
    send(12'd7,  32'h0000_00CC, 32'd3);
    send(12'd7,  32'h0000_00CC, 32'd4);
    wait_drain(200, "directed");
    check("empty_bucket_a5",  mem[5],  {32'h0A00_0001, 32'd3, 1'b0, 31'd0});
    check("hit_bucket_a10",   mem[10], {32'h0000_00AA, 32'd14, 1'b0, 31'd0});
    check("miss_bucket_a11",  mem[11], {32'h0000_00AA, 32'd10, 1'b0, 31'd5});
    check("evict_bucket_a12", mem[12], {32'h0000_00BB, 32'd3, 1'b1, 31'd0});
    check("fwd_bucket_a7",    mem[7],  {32'h0000_00CC, 32'd9, 1'b0, 31'd0});

    // random traffic on a small address/key space so conflicts and forwarding are frequent
    for (int i = 0; i < 600; i++) begin
      bus.light_out_alf2 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        a = 12'($urandom_range(0, 15));
        k = 32'hC0DE_0000 + 32'($urandom_range(0, 2));
        v = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 20));
        send(a, k, v);
      end
    end
    bus.light_out_alf2 = 1'b0;
    wait_drain(2000, "random");

    // fill the light FIFO with pops blocked and watch the almost-full threshold
    bus.light_out_alf2 = 1'b1;
    preload(12'd100, {32'h0000_0111, 32'h1000_0000, 1'b0, 31'd0});
    repeat (2) @(posedge clk);
    #1;
    alf_pushes = 0;
    alf_phase  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(12'd100, 32'h0000_0222, 32'(i + 1));
    end
    repeat (6) @(posedge clk);
    #1;
    alf_phase = 1'b0;
    check("alf_pushes_seen", alf_pushes, 400);
    check("alf_high_when_full", bus.item_alf2, 1);
    check("no_overflow_err", dut.w_overflow_err, 0);
    bus.light_out_alf2 = 1'b0;
    wait_drain(1500, "alf_drain");
    check("alf_low_after_drain", bus.item_alf2, 0);
    check("no_overflow_final", dut.w_overflow_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
